// File: rtl/pb_mailbox_pkg.sv
// Shared constants for the producer-to-consumer PicoBlaze mailbox.
package pb_mailbox_pkg;

  // Default kcpsm3 port IDs
  localparam logic [7:0] DEF_DATA_PORT_ID   = 8'h01;
  localparam logic [7:0] DEF_STATUS_PORT_ID = 8'h02;
  localparam logic [7:0] DEF_CTRL_PORT_ID   = 8'h04;

  // Status byte bit positions; the count field occupies [ST_CNT_LSB +: 4]
  localparam int unsigned ST_EMPTY   = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_UDF     = 3;
  localparam int unsigned ST_CNT_LSB = 4;

  // Control byte bit positions; the threshold field occupies [CTRL_THR_LSB +: 4]
  localparam int unsigned CTRL_CLR_OVF = 0;
  localparam int unsigned CTRL_CLR_UDF = 1;
  localparam int unsigned CTRL_THR_LSB = 4;

  typedef enum logic {
    IRQ_LEVEL = 1'b0,
    IRQ_EDGE  = 1'b1
  } irq_mode_e;

endpackage

// File: rtl/mailbox_fifo_core.sv
// FIFO storage, pointers, occupancy and push/pop acceptance for pb_mailbox.
module mailbox_fifo_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_req,
  input  logic              pop_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [CW-1:0]     count,
  output logic [CW-1:0]     count_next,
  output logic              full,
  output logic              empty,
  output logic              push_ok,
  output logic              pop_ok
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Pop is judged on the current count only, so a same-cycle push into an
  // empty FIFO cannot satisfy it; a push at full is allowed when a pop frees a slot.
  assign pop_ok  = pop_req & ~empty;
  assign push_ok = push_req & (~full | pop_ok);

  assign count_next = count + CW'(push_ok) - CW'(pop_ok);
  assign rd_data    = empty ? '0 : mem[rd_ptr];

  // Storage write on an accepted push
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

endmodule

// File: rtl/pb_mailbox.sv
// Interrupt-driven FIFO mailbox between a producer and a consumer kcpsm3,
// with status readback, sticky error flags and a programmable IRQ threshold.
module pb_mailbox
  import pb_mailbox_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned DEPTH          = 16,
  parameter logic [7:0]  DATA_PORT_ID   = DEF_DATA_PORT_ID,
  parameter logic [7:0]  STATUS_PORT_ID = DEF_STATUS_PORT_ID,
  parameter logic [7:0]  CTRL_PORT_ID   = DEF_CTRL_PORT_ID,
  parameter int unsigned IRQ_MODE       = 0,
  parameter int unsigned IRQ_THRESHOLD  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        prod_port_id,
  input  logic [DATA_W-1:0] prod_out_port,
  input  logic              prod_write_strobe,
  output logic              prod_full,
  input  logic [7:0]        cons_port_id,
  input  logic              cons_read_strobe,
  input  logic              cons_write_strobe,
  input  logic [7:0]        cons_out_port,
  output logic [DATA_W-1:0] cons_in_port,
  output logic              interrupt,
  input  logic              interrupt_ack
);

  localparam int unsigned CW        = $clog2(DEPTH + 1);
  localparam bit          EDGE_MODE = (IRQ_MODE == 32'(IRQ_EDGE));

  logic              push_req, pop_req, ctrl_wr;
  logic              push_ok, pop_ok, full, empty;
  logic [CW-1:0]     count, count_next;
  logic [DATA_W-1:0] head;

  logic              ovf, udf;
  logic [CW-1:0]     thr, thr_load;
  logic [3:0]        thr_nib, cnt_sat;
  logic [7:0]        status;
  logic              cond, cond_q, irq_set;
  logic              unused_ctrl_bits;

  assign push_req = prod_write_strobe & (prod_port_id == DATA_PORT_ID);
  assign pop_req  = cons_read_strobe  & (cons_port_id == DATA_PORT_ID);
  assign ctrl_wr  = cons_write_strobe & (cons_port_id == CTRL_PORT_ID);

  assign unused_ctrl_bits = ^cons_out_port[3:2];

  mailbox_fifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_req   (push_req),
    .pop_req    (pop_req),
    .wr_data    (prod_out_port),
    .rd_data    (head),
    .count      (count),
    .count_next (count_next),
    .full       (full),
    .empty      (empty),
    .push_ok    (push_ok),
    .pop_ok     (pop_ok)
  );

  assign cnt_sat  = (32'(count) >= 32'd15) ? 4'hF : 4'(count);
  assign thr_nib  = cons_out_port[CTRL_THR_LSB +: 4];
  assign thr_load = (32'(thr_nib) > DEPTH) ? CW'(DEPTH) : CW'(thr_nib);

  // Assemble the consumer-visible status byte
  always_comb begin
    status                     = '0;
    status[ST_EMPTY]           = empty;
    status[ST_FULL]            = full;
    status[ST_OVF]             = ovf;
    status[ST_UDF]             = udf;
    status[ST_CNT_LSB +: 4]    = cnt_sat;
  end

  // Sticky error flags; a new event in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= (ovf & ~(ctrl_wr & cons_out_port[CTRL_CLR_OVF])) | (push_req & ~push_ok);
      udf <= (udf & ~(ctrl_wr & cons_out_port[CTRL_CLR_UDF])) | (pop_req & ~pop_ok);
    end
  end

  // Interrupt threshold, loaded only by a nonzero control nibble
  always_ff @(posedge clk) begin
    if (reset) begin
      thr <= CW'(IRQ_THRESHOLD);
    end else if (ctrl_wr && (thr_nib != 4'd0)) begin
      thr <= thr_load;
    end
  end

  assign cond    = (count >= thr);
  assign irq_set = EDGE_MODE ? (cond & ~cond_q) : cond;

  // Pending interrupt; acknowledge takes priority over a same-cycle set
  always_ff @(posedge clk) begin
    if (reset) begin
      cond_q    <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      cond_q <= cond;
      if (interrupt_ack) begin
        interrupt <= 1'b0;
      end else if (irq_set) begin
        interrupt <= 1'b1;
      end
    end
  end

  // Registered consumer read mux and producer full indication
  always_ff @(posedge clk) begin
    if (reset) begin
      cons_in_port <= '0;
      prod_full    <= 1'b0;
    end else begin
      prod_full <= (count_next == CW'(DEPTH));
      if (cons_port_id == DATA_PORT_ID) begin
        cons_in_port <= head;
      end else if (cons_port_id == STATUS_PORT_ID) begin
        cons_in_port <= DATA_W'(status);
      end else begin
        cons_in_port <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pb_mailbox.sv
// Bench for pb_mailbox: a level-mode and an edge-mode instance share stimulus
// and are compared every cycle against a queue-based reference model.
module tb_pb_mailbox;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] prod_port_id, prod_out_port, cons_port_id, cons_out_port;
  logic       prod_write_strobe, cons_read_strobe, cons_write_strobe, interrupt_ack;
  logic       full_l, full_e, irq_l, irq_e;
  logic [7:0] cin_l, cin_e;

  always #5 clk = ~clk;

  pb_mailbox #(.DATA_W(8), .DEPTH(DEPTH), .IRQ_MODE(0), .IRQ_THRESHOLD(1)) dut_l (
    .clk(clk), .reset(reset), .prod_port_id(prod_port_id), .prod_out_port(prod_out_port),
    .prod_write_strobe(prod_write_strobe), .prod_full(full_l), .cons_port_id(cons_port_id),
    .cons_read_strobe(cons_read_strobe), .cons_write_strobe(cons_write_strobe),
    .cons_out_port(cons_out_port), .cons_in_port(cin_l), .interrupt(irq_l),
    .interrupt_ack(interrupt_ack));

  pb_mailbox #(.DATA_W(8), .DEPTH(DEPTH), .IRQ_MODE(1), .IRQ_THRESHOLD(1)) dut_e (
    .clk(clk), .reset(reset), .prod_port_id(prod_port_id), .prod_out_port(prod_out_port),
    .prod_write_strobe(prod_write_strobe), .prod_full(full_e), .cons_port_id(cons_port_id),
    .cons_read_strobe(cons_read_strobe), .cons_write_strobe(cons_write_strobe),
    .cons_out_port(cons_out_port), .cons_in_port(cin_e), .interrupt(irq_e),
    .interrupt_ack(interrupt_ack));

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  logic [7:0]  q[$];
  bit          m_ovf, m_udf, m_pl, m_pe, m_condq, m_full;
  int unsigned m_thr;
  logic [7:0]  m_cin;

  typedef struct {
    bit         pw;
    logic [7:0] pd;
    logic [7:0] cport;
    bit         crd;
    bit         ack;
    logic [7:0] e_cin;
    bit         e_irq;
    bit         e_full;
  } vec_t;
  vec_t tv[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] model_status();
    int n;
    logic [3:0] c;
    n = q.size();
    c = (n >= 15) ? 4'hF : 4'(n);
    return {c, m_udf, m_ovf, (n == DEPTH), (n == 0)};
  endfunction

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    int  n;
    bit  push, pop, ctrl, cond, pop_ok, push_ok;
    int unsigned nib;
    if (reset) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_pl = 0; m_pe = 0; m_condq = 0; m_full = 0;
      m_thr = 1; m_cin = 8'h00;
    end else begin
      n       = q.size();
      push    = prod_write_strobe && (prod_port_id == 8'h01);
      pop     = cons_read_strobe && (cons_port_id == 8'h01);
      ctrl    = cons_write_strobe && (cons_port_id == 8'h04);
      cond    = (n >= int'(m_thr));
      pop_ok  = pop && (n > 0);
      push_ok = push && ((n < DEPTH) || pop_ok);
      if (cons_port_id == 8'h01)      m_cin = (n > 0) ? q[0] : 8'h00;
      else if (cons_port_id == 8'h02) m_cin = model_status();
      else                            m_cin = 8'h00;
      m_ovf = (m_ovf && !(ctrl && cons_out_port[0])) || (push && !push_ok);
      m_udf = (m_udf && !(ctrl && cons_out_port[1])) || (pop && !pop_ok);
      nib = cons_out_port[7:4];
      if (ctrl && nib != 0) m_thr = (nib > DEPTH) ? DEPTH : nib;
      if (interrupt_ack) begin
        m_pl = 0; m_pe = 0;
      end else begin
        if (cond) m_pl = 1;
        if (cond && !m_condq) m_pe = 1;
      end
      m_condq = cond;
      if (pop_ok) void'(q.pop_front());
      if (push_ok) q.push_back(prod_out_port);
      m_full = (q.size() == DEPTH);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("cons_in_port_lvl", cin_l, m_cin);
    check("cons_in_port_edge", cin_e, m_cin);
    check("prod_full_lvl", full_l, m_full);
    check("prod_full_edge", full_e, m_full);
    check("interrupt_lvl", irq_l, m_pl);
    check("interrupt_edge", irq_e, m_pe);
  endtask

  task automatic set_idle();
    reset = 0; prod_port_id = 8'h00; prod_out_port = 8'h00; prod_write_strobe = 0;
    cons_port_id = 8'h00; cons_read_strobe = 0; cons_write_strobe = 0;
    cons_out_port = 8'h00; interrupt_ack = 0;
  endtask

  task automatic do_reset();
    set_idle(); reset = 1; cycle(); set_idle();
  endtask

  task automatic push(input logic [7:0] d);
    set_idle(); prod_port_id = 8'h01; prod_write_strobe = 1; prod_out_port = d; cycle();
  endtask

  task automatic pop();
    set_idle(); cons_port_id = 8'h01; cons_read_strobe = 1; cycle();
  endtask

  task automatic peek(input logic [7:0] port);
    set_idle(); cons_port_id = port; cycle();
  endtask

  task automatic ctrl_wr(input logic [7:0] v);
    set_idle(); cons_port_id = 8'h04; cons_write_strobe = 1; cons_out_port = v; cycle();
  endtask

  task automatic ack();
    set_idle(); interrupt_ack = 1; cycle();
  endtask

  task automatic push_pop(input logic [7:0] d);
    set_idle(); prod_port_id = 8'h01; prod_write_strobe = 1; prod_out_port = d;
    cons_port_id = 8'h01; cons_read_strobe = 1; cycle();
  endtask

  initial begin
    set_idle();
    m_thr = 1;

    // Basic write/read, table driven
    tv[0] = '{1'b1, 8'hA5, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tv[1] = '{1'b1, 8'h3C, 8'h01, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
    tv[2] = '{1'b0, 8'h00, 8'h01, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
    tv[3] = '{1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    tv[4] = '{1'b0, 8'h00, 8'h01, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};
    tv[5] = '{1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0};
    tv[6] = '{1'b0, 8'h00, 8'h02, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    tv[7] = '{1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0};

    do_reset();
    check("reset_cons_in", cin_l, 8'h00);
    check("reset_irq", irq_l, 1'b0);
    check("reset_full", full_l, 1'b0);
    for (int i = 0; i < 8; i++) begin
      set_idle();
      prod_port_id = 8'h01;
      prod_write_strobe = tv[i].pw;
      prod_out_port = tv[i].pd;
      cons_port_id = tv[i].cport;
      cons_read_strobe = tv[i].crd;
      interrupt_ack = tv[i].ack;
      cycle();
      check($sformatf("vec%0d_cons_in", i), cin_l, tv[i].e_cin);
      check($sformatf("vec%0d_irq", i), irq_l, tv[i].e_irq);
      check($sformatf("vec%0d_full", i), full_l, tv[i].e_full);
    end

    // Fill, overflow, drain
    do_reset();
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    check("t2_full", full_l, 1'b1);
    push(8'hFF);
    peek(8'h02);
    check("t2_status_ovf", cin_l, 8'hF6);
    for (int i = 0; i < 16; i++) begin
      pop();
      check("t2_drain", cin_l, 8'(8'h10 + i));
    end
    peek(8'h01);
    check("t2_empty_head", cin_l, 8'h00);
    peek(8'h02);
    check("t2_status_after", cin_l, 8'h05);

    // Simultaneous push/pop at full and at empty
    do_reset();
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    push_pop(8'h77);
    check("t3_full_head", cin_l, 8'h20);
    check("t3_full_kept", full_l, 1'b1);
    peek(8'h02);
    check("t3_full_status", cin_l, 8'hF2);
    do_reset();
    push_pop(8'h99);
    check("t3_empty_head", cin_l, 8'h00);
    peek(8'h02);
    check("t3_empty_status", cin_l, 8'h18);
    peek(8'h01);
    check("t3_empty_data", cin_l, 8'h99);

    // Level threshold 4
    do_reset();
    ctrl_wr(8'h40);
    for (int i = 0; i < 4; i++) begin
      push(8'(i));
      check("t4_irq_low", irq_l, 1'b0);
    end
    peek(8'h00);
    check("t4_irq_rise", irq_l, 1'b1);
    ack();
    check("t4_ack_clear", irq_l, 1'b0);
    peek(8'h00);
    check("t4_reassert", irq_l, 1'b1);

    // Edge threshold 2
    do_reset();
    ctrl_wr(8'h20);
    push(8'h01);
    push(8'h02);
    check("t5_pre", irq_e, 1'b0);
    peek(8'h00);
    check("t5_fire", irq_e, 1'b1);
    peek(8'h00);
    check("t5_hold", irq_e, 1'b1);
    ack();
    check("t5_ack", irq_e, 1'b0);
    push(8'h03);
    for (int i = 0; i < 3; i++) begin
      peek(8'h00);
      check("t5_no_refire", irq_e, 1'b0);
    end
    pop();
    pop();
    peek(8'h00);
    push(8'h04);
    check("t5_refill_lag", irq_e, 1'b0);
    peek(8'h00);
    check("t5_refire", irq_e, 1'b1);

    // Reset mid-drain
    do_reset();
    ctrl_wr(8'h80);
    for (int i = 0; i < 17; i++) push(8'(i));
    for (int i = 0; i < 11; i++) pop();
    set_idle(); cons_port_id = 8'h02; cons_read_strobe = 1; reset = 1;
    cycle();
    check("t6_cons_in", cin_l, 8'h00);
    check("t6_irq", irq_l, 1'b0);
    check("t6_full", full_l, 1'b0);
    peek(8'h02);
    check("t6_status", cin_l, 8'h01);
    push(8'h5A);
    peek(8'h00);
    check("t6_thr_reset", irq_l, 1'b1);

    // Randomized traffic against the model
    do_reset();
    for (int blk = 0; blk < 6; blk++) begin
      int unsigned pbias, cbias;
      pbias = (blk % 3 == 0) ? 80 : ((blk % 3 == 1) ? 20 : 50);
      cbias = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 80 : 50);
      for (int i = 0; i < 500; i++) begin
        int unsigned sel;
        set_idle();
        reset = ($urandom_range(0, 299) == 0);
        prod_write_strobe = ($urandom_range(0, 99) < pbias);
        prod_port_id = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h01;
        prod_out_port = 8'($urandom);
        sel = $urandom_range(0, 4);
        cons_port_id = (sel == 0) ? 8'h02 : ((sel == 1) ? 8'h04 : ((sel == 2) ? 8'($urandom) : 8'h01));
        cons_read_strobe = ($urandom_range(0, 99) < cbias);
        cons_write_strobe = ($urandom_range(0, 19) == 0);
        cons_out_port = 8'($urandom);
        interrupt_ack = ($urandom_range(0, 9) == 0);
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
